vga_timing_drv: RTL

- Display-side end of the pixel interface: produces the pixel coordinates (vga_xide, vga_yide) that the game-logic block consumes, and samples its returned 8-bit colour (vga_data).
- Generates 800x600@72Hz VGA timing from the 50 MHz system clock, one pixel per clock.
- Drives vga_hs, vga_vs and vga_rgb to the board DAC/connector.
- Colour is blanked outside the active area.

---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_test_pattern.sv | 26 ++
 rtl/vga_timing_drv.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72Hz timing constants and 8-bit RRR_GGG_BB colour constants.
// Pure declarations: no logic, no latency.
// Used by the timing driver, the test-pattern generator and the game logic.
package vga_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BP     = 64;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1040

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 37;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 666

    // Sync regions are [START, END): END is the first count outside the pulse.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;               // 856
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;         // 976
    localparam int V_SYNC_START = V_ACTIVE + V_FP;               // 637
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;         // 643

    localparam logic SYNC_POL = 1'b1;

    typedef logic [7:0] rgb_t;

    localparam rgb_t WHITE   = 8'hff;
    localparam rgb_t YELLOW  = 8'hfc;
    localparam rgb_t CYAN    = 8'h1f;
    localparam rgb_t GREEN   = 8'h1c;
    localparam rgb_t MAGENTA = 8'he3;
    localparam rgb_t RED     = 8'he0;
    localparam rgb_t BLUE    = 8'h03;
    localparam rgb_t BLACK   = 8'h00;

    // Colour of each 100-pixel vertical bar, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Colour-bar test pattern with a one-pixel white border around the active area.
// Combinational: colour is valid in the same cycle as the coordinates.
// No backpressure; purely a function of x/y.
module vga_test_pattern
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output rgb_t       colour
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    // Border pixels override the bar colour; bars are 100 pixels wide.
    always_comb begin
        colour = bar_colour(3'(x / 10'd100));
        if (x == 10'd0 || x == X_LAST || y == 10'd0 || y == Y_LAST) begin
            colour = WHITE;
        end
    end

endmodule

// File: rtl/vga_timing_drv.sv
// VGA timing generator (800x600@72 from 50 MHz, 1 px/clk) with colour output stage.
// Coordinates are combinational from the counters; hs/vs/rgb/de/frame_start lag them by 1 clock.
// No backpressure: the display consumes one pixel every clock. Optional: VGA_TEST_PATTERN_EN.
module vga_timing_drv
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_data,
    output logic [9:0] vga_xide,
    output logic [9:0] vga_yide,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_rgb,
    output logic       vga_de,
    output logic       frame_start
);

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_FIN  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_FIN  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_act;
    logic        v_act;
    logic        active;
    logic        hs_region;
    logic        vs_region;
    rgb_t        pix;

    // Pixel/line counters; the line counter only steps when the pixel counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign h_act     = (h_cnt < H_ACT);
    assign v_act     = (v_cnt < V_ACT);
    assign active    = h_act && v_act;
    assign hs_region = (h_cnt >= HS_BEG) && (h_cnt < HS_FIN);
    assign vs_region = (v_cnt >= VS_BEG) && (v_cnt < VS_FIN);

    // Coordinates are clamped to 0 in blanking so game logic never sees an out-of-range index.
    assign vga_xide = h_act ? h_cnt[9:0] : '0;
    assign vga_yide = v_act ? v_cnt : '0;

`ifdef VGA_TEST_PATTERN_EN
    rgb_t pattern;
    logic unused_vga_data;

    vga_test_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pattern (
        .x      (vga_xide),
        .y      (vga_yide),
        .colour (pattern)
    );

    assign pix             = pattern;
    assign unused_vga_data = ^vga_data;
`else
    assign pix = vga_data;
`endif

    // Output stage: everything the connector sees is registered, one clock behind the coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rgb     <= '0;
            vga_de      <= 1'b0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= active ? pix : '0;
            vga_de      <= active;
            vga_hs      <= hs_region ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= vs_region ? SYNC_POL : ~SYNC_POL;
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
        end
    end

endmodule
